// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : riscv_pkg                                              |
// | Shared fetch-stage constants, the fetch FSM state encoding and   |
// | the fetch-address range helper.                                  |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 : what an empty IF/ID slot presents to decode
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  // A fetch is legal only if the whole 4-byte word lies inside the memory
  function automatic logic fetch_in_range(input logic [XLEN-1:0] pc,
                                          input logic [XLEN-1:0] last_pc);
    return (pc <= last_pc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : if_id_slot                                             |
// | Single-entry IF/ID pipeline register holding {pc, instr} with a  |
// | valid flag. Priority: flush > load > consume; otherwise hold.    |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module if_id_slot
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic            consume,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;

  // Slot register: a flush drops the entry, pc/instr payload only changes on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_pc    <= pc_in;
      r_instr <= instr_in;
    end else if (consume) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign pc    = r_pc;
  assign instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : imem_fetch_ctrl                                        |
// | Fetch-stage sequencer: owns the PC, addresses the combinational  |
// | instruction memory and fills the IF/ID slot with a valid/ready   |
// | handshake. Halts on an all-zero word or an out-of-range fetch;   |
// | a redirect restarts it.                                          |
// | Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect  |
// | target faults and halts instead of being word-aligned).          |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module imem_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [1:0]  C_ST_BOOT = FETCH_BOOT;
  localparam logic [1:0]  C_ST_RUN  = FETCH_RUN;
  localparam logic [1:0]  C_ST_HALT = FETCH_HALT;
  localparam logic [31:0] C_LAST_PC = 32'(MEM_BYTES - 4);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_fault;

  logic        w_run;
  logic        w_in_range;
  logic        w_slot_free;
  logic        w_fetch_ok;
  logic        w_load;
  logic        w_zero_halt;
  logic        w_range_fault;
  logic        w_consume;
  logic        w_redir_bad;
  logic [31:0] w_redir_pc;

  assign w_run       = (r_state == C_ST_RUN);
  assign w_in_range  = fetch_in_range(r_pc, C_LAST_PC);
  assign w_slot_free = !if_valid || id_ready;

  // Everything except the fetched word itself allows a fetch this cycle
  assign w_fetch_ok    = w_run && !redirect_valid && w_slot_free && w_in_range;
  assign w_load        = w_fetch_ok && (imem_dout != 32'h0);
  assign w_zero_halt   = w_fetch_ok && (imem_dout == 32'h0);
  assign w_range_fault = w_run && !redirect_valid && !w_in_range;
  assign w_consume     = id_ready && if_valid && !w_load;

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned targets are kept verbatim so the faulting address is visible
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc  = redirect_pc;
`else
  // Low address bits are dropped: targets always land on a word boundary
  assign w_redir_bad = 1'b0;
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
`endif

  // PC, FSM state and sticky fault; a redirect overrides every other update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= C_ST_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= w_redir_pc;
      r_fault <= w_redir_bad;
      r_state <= w_redir_bad ? C_ST_HALT : C_ST_RUN;
    end else begin
      case (r_state)
        C_ST_BOOT: r_state <= C_ST_RUN;
        C_ST_RUN: begin
          if (w_range_fault) begin
            r_fault <= 1'b1;
            r_state <= C_ST_HALT;
          end else if (w_zero_halt) begin
            r_state <= C_ST_HALT;
          end else if (w_load) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        C_ST_HALT: r_state <= C_ST_HALT;
        default:   r_state <= C_ST_HALT;
      endcase
    end
  end

  if_id_slot u_slot (
    .clk      (clk),
    .rst      (reset),
    .flush    (redirect_valid),
    .load     (w_load),
    .consume  (w_consume),
    .pc_in    (r_pc),
    .instr_in (imem_dout),
    .valid    (if_valid),
    .pc       (if_pc),
    .instr    (if_instr)
  );

  assign imem_addr   = r_pc;
  assign halted      = (r_state == C_ST_HALT);
  assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_imem_fetch_ctrl                                     |
// | Directed bench for imem_fetch_ctrl with a word-array memory      |
// | model; delivered {pc, instr} pairs are scoreboarded, state and   |
// | address outputs are checked directly.                            |
// | Honours FETCH_ALIGN_CHECK_EN to match the DUT build.             |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_imem_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] mem [0:63];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (256)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory, reads as zero outside the 256-byte array
  assign imem_dout = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back({p, i});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every slot handed to decode (not squashed by a redirect) must match the queue head
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery got pc=%h instr=%h expected none", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (if_pc !== mon_e.pc || if_instr !== mon_e.instr) begin
          errors++;
          $display("FAIL delivery got pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, if_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h13 + 32'(i) * 32'h0010_0000;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0000_0093;
    mem[2] = 32'h0000_0113;
    mem[3] = 32'h0000_0000;

    reset          = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) step();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Sequential run from reset
    reset    = 1'b0;
    id_ready = 1'b1;
    push(32'h0, 32'h0000_0013);
    push(32'h4, 32'h0000_0093);
    push(32'h8, 32'h0000_0113);
    step();
    chk("boot_no_load", {31'b0, if_valid}, 32'd0);
    step();
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    step();
    chk("second_pc", if_pc, 32'h4);

    // Stall three cycles while slot holds pc 4
    id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h0000_0093);
      chk("stall_addr", imem_addr, 32'h8);
    end
    id_ready = 1'b1;
    step();
    chk("resume_pc", if_pc, 32'h8);

    // Zero word at 0x0C halts after slot 8 drains
    step();
    chk("zero_halted", {31'b0, halted}, 32'd1);
    chk("zero_if_valid", {31'b0, if_valid}, 32'd0);
    chk("zero_addr", imem_addr, 32'hC);
    step();
    chk("zero_addr_hold", imem_addr, 32'hC);

    // Redirect out of HALT to 0x40
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    push(32'h40, 32'h0100_0013);
    step();
    redirect_valid = 1'b0;
    chk("redir_unhalt", {31'b0, halted}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    step();
    chk("redir_target_pc", if_pc, 32'h40);

    // Redirect while slot 0x44 is valid: that slot is dropped
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    push(32'h80, 32'h0200_0013);
    step();
    redirect_valid = 1'b0;
    chk("squash_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("squash_target_pc", if_pc, 32'h80);

    // Last legal word, then out-of-range fault
    @(negedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    push(32'hFC, 32'h03F0_0013);
    step();
    redirect_valid = 1'b0;
    chk("edge_addr", imem_addr, 32'hFC);
    step();
    chk("edge_pc", if_pc, 32'hFC);
    chk("edge_no_fault", {31'b0, fetch_fault}, 32'd0);
    step();
    chk("range_fault", {31'b0, fetch_fault}, 32'd1);
    chk("range_halted", {31'b0, halted}, 32'd1);
    chk("range_addr", imem_addr, 32'h100);
    chk("range_if_valid", {31'b0, if_valid}, 32'd0);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
`ifdef FETCH_ALIGN_CHECK_EN
    step();
    redirect_valid = 1'b0;
    chk("align_fault", {31'b0, fetch_fault}, 32'd1);
    chk("align_halted", {31'b0, halted}, 32'd1);
    chk("align_addr", imem_addr, 32'h6);
    step();
    chk("align_if_valid", {31'b0, if_valid}, 32'd0);
`else
    push(32'h4, 32'h0000_0093);
    push(32'h8, 32'h0000_0113);
    step();
    redirect_valid = 1'b0;
    chk("align_addr", imem_addr, 32'h4);
    chk("align_fault_clr", {31'b0, fetch_fault}, 32'd0);
    step();
    chk("align_pc", if_pc, 32'h4);
    step();
    step();
    chk("align_rehalt", {31'b0, halted}, 32'd1);
`endif

    // Asynchronous reset in the middle of a stall
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("prestall_pc", if_pc, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    chk("async_if_valid", {31'b0, if_valid}, 32'd0);
    chk("async_if_pc", if_pc, 32'h0);
    chk("async_if_instr", if_instr, 32'h0000_0013);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_fault", {31'b0, fetch_fault}, 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
